// File: rtl/message_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : message_buffer_pkg
//  Description : Message widths, buffer entry layout and byte-lane helper
//                shared by message_extractor and message_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package message_buffer_pkg;

    localparam int MSG_DATA_W = 256;
    localparam int MSG_MASK_W = 32;
    localparam int MSG_LEN_W  = 6;
    localparam int MSG_BYTE_W = 8;

    // One stored message. The length travels with the data so the read side
    // never has to recount the mask.
    typedef struct packed {
        logic [MSG_DATA_W-1:0] data;
        logic [MSG_MASK_W-1:0] mask;
        logic [MSG_LEN_W-1:0]  len;
    } msg_entry_t;

    // Byte lane i occupies bits [8*i+7 : 8*i] of the message data.
    function automatic logic [MSG_BYTE_W-1:0] msg_byte(
        input logic [MSG_DATA_W-1:0] data,
        input int unsigned           idx
    );
        return data[idx*MSG_BYTE_W +: MSG_BYTE_W];
    endfunction

endpackage : message_buffer_pkg
`default_nettype wire

// File: rtl/msg_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : msg_popcount
//  Description : Counts the valid byte lanes of a message mask (0..32).
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_popcount
    import message_buffer_pkg::*;
(
    input  logic [MSG_MASK_W-1:0] mask,
    output logic [MSG_LEN_W-1:0]  count
);

    // Ripple sum of the mask bits; 6 bits hold the all-ones case of 32.
    always_comb begin
        count = '0;
        for (int i = 0; i < MSG_MASK_W; i++) begin
            count = count + MSG_LEN_W'(mask[i]);
        end
    end

endmodule : msg_popcount
`default_nettype wire

// File: rtl/message_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : message_buffer
//  Description : First-word-fall-through message FIFO behind message_extractor.
//                Input has no backpressure; messages arriving while full are
//                dropped and counted. Output is a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module message_buffer
    import message_buffer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [MSG_DATA_W-1:0] in_data,
    input  logic [MSG_MASK_W-1:0] in_bytemask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MSG_DATA_W-1:0] out_data,
    output logic [MSG_MASK_W-1:0] out_bytemask,
    output logic [MSG_LEN_W-1:0]  out_len,
    output logic [ADDR_W:0]       level,
    output logic [CNT_W-1:0]      drop_count,
    output logic                  overflow
);

    localparam logic [ADDR_W:0]   c_full_level = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_level_one  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one    = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  c_cnt_one    = CNT_W'(1);

    msg_entry_t          r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_level;
    logic [CNT_W-1:0]    r_drop_count;
    logic                r_overflow;

    logic [MSG_LEN_W-1:0] w_in_len;
    logic                 w_push_req;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_wr_en;
    logic                 w_drop;
    msg_entry_t           w_head;

    // Length is computed once on the way in and stored with the entry.
    msg_popcount u_popcount (
        .mask  (in_bytemask),
        .count (w_in_len)
    );

    // A zero-mask message carries nothing and is ignored outright.
    assign w_push_req = in_valid && (in_bytemask != '0);
    assign w_full     = (r_level == c_full_level);
    assign w_pop      = out_valid && out_ready;
    // When full, a same-cycle pop frees the head slot, so the push still fits.
    assign w_wr_en    = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    // Entry storage needs no reset: level alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= '{data: in_data, mask: in_bytemask, len: w_in_len};
        end
    end

    // Pointers, occupancy and drop accounting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_wr_en && !w_pop) begin
                r_level <= r_level + c_level_one;
            end else if (w_pop && !w_wr_en) begin
                r_level <= r_level - c_level_one;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + c_cnt_one;
                end
            end
        end
    end

    // Head entry falls straight through; outputs read as zero when empty.
    assign w_head       = r_mem[r_rd_ptr];
    assign out_valid    = (r_level != '0);
    assign out_data     = out_valid ? w_head.data : '0;
    assign out_bytemask = out_valid ? w_head.mask : '0;
    assign out_len      = out_valid ? w_head.len  : '0;

    assign level      = r_level;
    assign drop_count = r_drop_count;
    assign overflow   = r_overflow;

endmodule : message_buffer
`default_nettype wire

// File: tb/tb_message_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_message_buffer
//  Description : Scoreboard bench for message_buffer. The driver pushes the
//                expected message for every accepted input; a monitor compares
//                the presented head against the queue front every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_message_buffer;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 16;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  m;
        logic [5:0]   l;
    } exp_t;

    logic               clk;
    logic               reset_n;
    logic               in_valid;
    logic [255:0]       in_data;
    logic [31:0]        in_bytemask;
    logic               out_valid;
    logic               out_ready;
    logic [255:0]       out_data;
    logic [31:0]        out_bytemask;
    logic [5:0]         out_len;
    logic [ADDR_W:0]    level;
    logic [CNT_W-1:0]   drop_count;
    logic               overflow;

    exp_t               sb[$];
    int                 m_level;
    int                 m_drops;
    logic               m_ovf;
    int                 errors;
    int                 checks;

    message_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_bytemask  (in_bytemask),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_bytemask (out_bytemask),
        .out_len      (out_len),
        .level        (level),
        .drop_count   (drop_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the head must match the oldest expected message;
    // it is retired when the consumer is ready.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL head_unexpected: got out_valid=1 expected no message at %0t", $time);
                end else begin
                    chk("head_data", out_data, sb[0].d);
                    chk("head_mask", 256'(out_bytemask), 256'(sb[0].m));
                    chk("head_len", 256'(out_len), 256'(sb[0].l));
                    if (out_ready) void'(sb.pop_front());
                end
            end else if (sb.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL head_missing: got out_valid=0 expected %0d queued at %0t", sb.size(), $time);
            end
        end
    end

    // One clock of stimulus issued just after a rising edge; the model of
    // occupancy and drops is advanced and checked after the next edge.
    task automatic step(input logic v, input logic [255:0] d, input logic [31:0] m,
                        input logic [5:0] l, input logic rdy);
        logic push, pop;
        exp_t e;
        in_valid    = v;
        in_data     = d;
        in_bytemask = m;
        out_ready   = rdy;
        push = v && (m != 32'h0);
        pop  = (m_level > 0) && rdy;
        @(posedge clk);
        #1;
        if (pop) m_level--;
        if (push) begin
            if (m_level < DEPTH) begin
                e.d = d; e.m = m; e.l = l;
                sb.push_back(e);
                m_level++;
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
        end
        chk("level", 256'(level), 256'(m_level));
        chk("drop_count", 256'(drop_count), 256'(m_drops));
        chk("overflow", 256'(overflow), 256'(m_ovf));
        chk("out_valid", 256'(out_valid), 256'(m_level != 0));
        if (m_level == 0) begin
            chk("empty_data", out_data, 256'h0);
            chk("empty_mask", 256'(out_bytemask), 256'h0);
            chk("empty_len", 256'(out_len), 256'h0);
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && m_level > 0; i++) step(1'b0, 256'h0, 32'h0, 6'd0, 1'b1);
        chk("drained_level", 256'(level), 256'h0);
    endtask

    initial begin
        logic [255:0] rd;
        logic [31:0]  rm;
        errors = 0; checks = 0;
        m_level = 0; m_drops = 0; m_ovf = 1'b0;

        // Reset held with a message presented on the input.
        reset_n = 1'b0; in_valid = 1'b1; in_data = '1; in_bytemask = '1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 256'(out_valid), 256'h0);
        chk("rst_level", 256'(level), 256'h0);
        chk("rst_drop_count", 256'(drop_count), 256'h0);
        chk("rst_overflow", 256'(overflow), 256'h0);
        chk("rst_out_data", out_data, 256'h0);
        chk("rst_out_len", 256'(out_len), 256'h0);
        in_valid = 1'b0; in_data = '0; in_bytemask = '0;
        #2 reset_n = 1'b1;

        // Single message, eight bytes.
        step(1'b1, 256'h0102030405060708, 32'h000000FF, 6'd8, 1'b1);
        step(1'b0, 256'h0, 32'h0, 6'd0, 1'b1);

        // Fill with masks 0x1..0xFF, ninth push dropped, then drain in order.
        for (int k = 0; k < 8; k++)
            step(1'b1, 256'(k + 1) * 256'h1111, (32'h1 << (k + 1)) - 32'h1, 6'(k + 1), 1'b0);
        step(1'b1, 256'hDEAD, 32'h0000000F, 6'd4, 1'b0);
        drain(12);

        // Full with simultaneous push and pop: accepted, emerges last.
        for (int k = 0; k < 8; k++)
            step(1'b1, 256'(k + 100), 32'h00000003, 6'd2, 1'b0);
        step(1'b1, 256'hBEEF, 32'hFFFF0000, 6'd16, 1'b1);
        drain(12);

        // Zero mask discarded, full mask counts 32.
        step(1'b1, 256'h55, 32'h00000000, 6'd0, 1'b1);
        step(1'b1, {256{1'b1}}, 32'hFFFFFFFF, 6'd32, 1'b1);
        drain(4);

        // Stalled head must hold steady.
        step(1'b1, 256'hCAFE_F00D, 32'h0000F0F0, 6'd8, 1'b0);
        repeat (5) step(1'b0, 256'h0, 32'h0, 6'd0, 1'b0);

        // Twenty pushes with a randomly ready consumer, crossing pointer wrap.
        for (int j = 0; j < 20; j++) begin
            for (int w = 0; w < 8; w++) rd[w*32 +: 32] = $urandom();
            rm = $urandom();
            if (rm == 32'h0) rm = 32'h1;
            step(1'b1, rd, rm, 6'($countones(rm)), 1'($urandom_range(0, 1)));
        end
        drain(20);

        // Reset in the middle of traffic discards stored entries.
        step(1'b1, 256'hA1, 32'h1, 6'd1, 1'b0);
        step(1'b1, 256'hA2, 32'h3, 6'd2, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("midrst_level", 256'(level), 256'h0);
        chk("midrst_out_valid", 256'(out_valid), 256'h0);
        chk("midrst_overflow", 256'(overflow), 256'h0);
        sb.delete();
        m_level = 0; m_drops = 0; m_ovf = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(1'b1, 256'hB0, 32'h80000001, 6'd2, 1'b1);
        drain(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_message_buffer
`default_nettype wire
